// File: rtl/sb_bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : sb_bus_pkg
// Desc     : Shared types, widths and address-decode helper for the system-bus
//            memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package sb_bus_pkg;

    localparam int SB_DATA_W  = 32;
    localparam int SB_BURST_W = 8;
    localparam int SB_BE_W    = 4;

    // Responder FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR       = 3'd3,
        ERR      = 3'd4
    } sb_state_e;

    // The memory claims the aligned window of 4*2^aw bytes that contains
    // base; only the bits above the byte-within-window field are compared.
    function automatic logic sb_decode_hit(
        input logic [SB_DATA_W-1:0] addr,
        input logic [SB_DATA_W-1:0] base,
        input int unsigned          aw
    );
        return (addr >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_ram_be.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sb_ram_be
// Desc     : Single-port synchronous RAM, 2^ADDR_WIDTH x 32 bit, with
//            per-byte write enables and a registered (1-cycle) read port.
// Revision : 1.0 - initial release
// ============================================================================
module sb_ram_be
    import sb_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic [SB_BE_W-1:0]    we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [SB_DATA_W-1:0]  wdata_i,
    output logic [SB_DATA_W-1:0]  rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [SB_DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [SB_DATA_W-1:0] rdata_q;

    // Byte-masked write and registered read; contents have no reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < SB_BE_W; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sb_mem_responder
// Desc     : System-bus slave serving single/burst reads from on-chip word
//            memory and byte-enabled single/burst writes, with a write stall
//            window (busy) and an address-decode error pulse. All outputs are
//            zero whenever this block is not the active responder so they can
//            be OR-combined onto the shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module sb_mem_responder
    import sb_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS      = 32'h0000_0000,
    parameter int          ADDR_WIDTH        = 12,
    parameter int          READ_LATENCY      = 2,
    parameter int          WRITE_BUSY_CYCLES = 0
) (
    input  logic                  sb_clock_i,
    input  logic                  sb_reset_n_i,
    input  logic                  sb_begin_transaction_i,
    input  logic                  sb_end_transaction_i,
    input  logic [SB_DATA_W-1:0]  sb_address_data_i,
    input  logic [SB_BE_W-1:0]    sb_byte_enables_i,
    input  logic [SB_BURST_W-1:0] sb_burst_size_i,
    input  logic                  sb_read_n_write_i,
    input  logic                  sb_data_valid_i,
    input  logic                  sb_error_i,
    output logic [SB_DATA_W-1:0]  sb_address_data_o,
    output logic                  sb_data_valid_o,
    output logic                  sb_end_transaction_o,
    output logic                  sb_busy_o,
    output logic                  sb_error_o
);

    localparam int                    BUSY_W    = $clog2(WRITE_BUSY_CYCLES + 2);
    localparam logic [BUSY_W-1:0]     BUSY_LOAD = BUSY_W'(WRITE_BUSY_CYCLES);
    localparam logic [BUSY_W-1:0]     BUSY_ONE  = BUSY_W'(1);
    localparam logic [3:0]            WAIT_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);
    // With a latency of 1 the first read is issued in the begin cycle itself,
    // so the index register must already point at the second word.
    localparam logic [ADDR_WIDTH-1:0] RD_FIRST_STEP = (READ_LATENCY == 1) ? IDX_ONE : '0;
    localparam int                    BEATS_W   = SB_BURST_W + 1;

    sb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [BEATS_W-1:0]    beats_q, beats_d;
    logic [3:0]            wait_q, wait_d;
    logic [BUSY_W-1:0]     busy_q, busy_d;
    logic [SB_BE_W-1:0]    be_q, be_d;

    logic [ADDR_WIDTH-1:0] w_in_idx;
    logic                  w_hit;
    logic                  w_beat;
    logic                  w_own_end;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_abort;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [SB_BE_W-1:0]    w_ram_we;
    logic [SB_DATA_W-1:0]  w_ram_rdata;

    assign w_in_idx  = sb_address_data_i[ADDR_WIDTH+1:2];
    assign w_hit     = sb_decode_hit(sb_address_data_i, BASE_ADDRESS, ADDR_WIDTH);

    // In RD_BURST the beat counter doubles as the end flag: zero remaining
    // beats means this is the end-of-burst cycle.
    assign w_beat    = (state_q == RD_BURST) && (beats_q != '0);
    assign w_own_end = (state_q == RD_BURST) && (beats_q == '0);

    // The master ending the write releases the stall in the same cycle.
    assign w_busy    = (state_q == WR) && (busy_q != '0) && !sb_end_transaction_i;
    assign w_accept  = (state_q == WR) && sb_data_valid_i && !w_busy
                       && (beats_q != '0) && !sb_error_i;

    // The bus-level end includes our own end pulse, which must not abort.
    assign w_abort   = sb_error_i || (sb_end_transaction_i && !w_own_end);

    // Next-state, index/counter updates and RAM port control.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        beats_d    = beats_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        be_d       = be_q;
        w_ram_addr = idx_q;
        w_ram_we   = '0;

        case (state_q)
            IDLE: begin
                w_ram_addr = w_in_idx;
                if (sb_begin_transaction_i) begin
                    if (w_hit) begin
                        beats_d = {1'b0, sb_burst_size_i} + 9'd1;
                        be_d    = sb_byte_enables_i;
                        if (sb_read_n_write_i) begin
                            idx_d   = w_in_idx + RD_FIRST_STEP;
                            wait_d  = WAIT_LOAD;
                            state_d = (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
                        end else begin
                            idx_d   = w_in_idx;
                            busy_d  = BUSY_LOAD;
                            state_d = WR;
                        end
                    end else begin
                        state_d = ERR;
                    end
                end
            end

            RD_WAIT: begin
                // The last wait cycle issues the first read so that its data
                // emerges from the registered RAM exactly on the first beat.
                if (wait_q <= 4'd1) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = RD_BURST;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            RD_BURST: begin
                // Every beat cycle pre-issues the next word; the extra read
                // after the last beat is harmless.
                if (beats_q != '0) begin
                    idx_d   = idx_q + IDX_ONE;
                    beats_d = beats_q - 9'd1;
                end else begin
                    state_d = IDLE;
                end
            end

            WR: begin
                if (busy_q != '0) begin
                    busy_d = busy_q - BUSY_ONE;
                end
                if (w_accept) begin
                    w_ram_we = be_q;
                    idx_d    = idx_q + IDX_ONE;
                    beats_d  = beats_q - 9'd1;
                end
                if (sb_end_transaction_i) begin
                    state_d = IDLE;
                end
            end

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && w_abort) begin
            state_d = IDLE;
        end
    end

    // State and transaction-context registers with synchronous active-low reset.
    always_ff @(posedge sb_clock_i) begin
        if (!sb_reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            beats_q <= '0;
            wait_q  <= '0;
            busy_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            be_q    <= be_d;
        end
    end

    // Flags a master starting a new transaction before this one finished.
    always @(posedge sb_clock_i) begin
        if (sb_reset_n_i && sb_begin_transaction_i) begin
            assert (state_q == IDLE);
        end
    end

    sb_ram_be #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (sb_clock_i),
        .we_i    (w_ram_we),
        .addr_i  (w_ram_addr),
        .wdata_i (sb_address_data_i),
        .rdata_o (w_ram_rdata)
    );

    assign sb_address_data_o    = w_beat ? w_ram_rdata : '0;
    assign sb_data_valid_o      = w_beat;
    assign sb_end_transaction_o = w_own_end;
    assign sb_busy_o            = w_busy;
    assign sb_error_o           = (state_q == ERR);

endmodule
`default_nettype wire

// File: tb/tb_sb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sb_mem_responder
// Desc     : Self-checking bench for sb_mem_responder: a cycle-indexed
//            expectation timeline built from the bus rules, an array memory
//            model, and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          AW    = 12;
    localparam int          RL    = 2;
    localparam int          WB    = 5;
    localparam int          DEPTH = 1 << AW;
    localparam int          MAXC  = 20000;

    logic        clk = 1'b0;
    logic        rst_n, beg, mend, merr, dvi, rnw;
    logic [31:0] adi;
    logic [3:0]  bei;
    logic [7:0]  bsz;
    logic [31:0] ado;
    logic        dvo, endo, busyo, erro;
    logic        end_bus, err_bus;

    // Bus-level end/error are the OR of master and responder.
    assign end_bus = mend | endo;
    assign err_bus = merr | erro;

    always #5 clk = ~clk;

    sb_mem_responder #(
        .BASE_ADDRESS      (BASE),
        .ADDR_WIDTH        (AW),
        .READ_LATENCY      (RL),
        .WRITE_BUSY_CYCLES (WB)
    ) dut (
        .sb_clock_i             (clk),
        .sb_reset_n_i           (rst_n),
        .sb_begin_transaction_i (beg),
        .sb_end_transaction_i   (end_bus),
        .sb_address_data_i      (adi),
        .sb_byte_enables_i      (bei),
        .sb_burst_size_i        (bsz),
        .sb_read_n_write_i      (rnw),
        .sb_data_valid_i        (dvi),
        .sb_error_i             (err_bus),
        .sb_address_data_o      (ado),
        .sb_data_valid_o        (dvo),
        .sb_end_transaction_o   (endo),
        .sb_busy_o              (busyo),
        .sb_error_o             (erro)
    );

    logic [31:0] mdl_mem [0:DEPTH-1];
    bit          exp_dv   [0:MAXC-1];
    bit          exp_end  [0:MAXC-1];
    bit          exp_busy [0:MAXC-1];
    bit          exp_err  [0:MAXC-1];
    bit   [31:0] exp_data [0:MAXC-1];
    logic [31:0] obs_data [0:MAXC-1];
    logic        obs_dv   [0:MAXC-1];
    logic        obs_busy [0:MAXC-1];
    logic        obs_err  [0:MAXC-1];
    logic        obs_end  [0:MAXC-1];
    logic [31:0] wq [$];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of every output against the expectation timeline.
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            obs_data[cyc] = ado;
            obs_dv[cyc]   = dvo;
            obs_busy[cyc] = busyo;
            obs_err[cyc]  = erro;
            obs_end[cyc]  = endo;
            n_checks++;
            if ({dvo, endo, busyo, erro, ado} ===
                {exp_dv[cyc], exp_end[cyc], exp_busy[cyc], exp_err[cyc], exp_data[cyc]}) begin
                n_pass++;
            end else begin
                $display("FAIL bus_outputs cycle %0d: got dv=%b end=%b busy=%b err=%b data=%h, expected dv=%b end=%b busy=%b err=%b data=%h",
                         cyc, dvo, endo, busyo, erro, ado,
                         exp_dv[cyc], exp_end[cyc], exp_busy[cyc], exp_err[cyc], exp_data[cyc]);
            end
        end
    end

    initial begin
        #(MAXC * 10 - 50);
        $display("FAIL watchdog: simulation did not finish within %0d cycles", MAXC);
        $fatal(1);
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        beg = 0; mend = 0; merr = 0; dvi = 0; rnw = 0;
        adi = '0; bei = '0; bsz = '0;
    endtask

    function automatic bit hit(input logic [31:0] a);
        return (a >> (AW + 2)) == (BASE >> (AW + 2));
    endfunction

    // After an abort or reset nothing more is expected from this transaction.
    task automatic clear_from(input int c);
        for (int i = c; i < c + 600 && i < MAXC; i++) begin
            exp_dv[i] = 0; exp_end[i] = 0; exp_busy[i] = 0; exp_err[i] = 0; exp_data[i] = '0;
        end
    endtask

    // kind: 0 none, 1 error_i, 2 end_i from master, 3 reset; applied at begin+off.
    task automatic do_read(input logic [31:0] addr, input int burst, input int kind, input int off);
        int b, n, idx, last;
        b = cyc; n = burst + 1; idx = int'(addr[AW+1:2]);
        beg = 1; adi = addr; rnw = 1; bsz = 8'(burst); bei = 4'($urandom);
        if (!hit(addr)) begin
            exp_err[b+1] = 1;
            last = b + 1;
        end else begin
            for (int k = 0; k < n; k++) begin
                exp_dv[b+RL+k]   = 1;
                exp_data[b+RL+k] = mdl_mem[(idx + k) % DEPTH];
            end
            exp_end[b+RL+n] = 1;
            last = b + RL + n;
        end
        step();
        beg = 0; rnw = 0; bsz = '0; bei = '0;
        while (cyc <= last) begin
            if (kind != 0 && cyc == b + off) begin
                if (kind == 1) merr = 1;
                else if (kind == 2) mend = 1;
                else rst_n = 0;
                clear_from(cyc + 1);
                step();
                merr = 0; mend = 0;
                if (kind == 3) begin
                    step();
                    rst_n = 1;
                end
                break;
            end
            adi = $urandom;
            step();
        end
        adi = '0;
    endtask

    // Sends beats until `stop` have been accepted, then `extra` more cycles
    // (garbage beats once the count is exhausted), then the master end.
    task automatic do_write(input logic [31:0] addr, input int burst, input logic [3:0] be,
                            input int dv_pct, input int stop, input int extra);
        int b, n, idx, acc, left, guard;
        logic [31:0] w;
        logic        dv;
        b = cyc; n = burst + 1; idx = int'(addr[AW+1:2]);
        acc = 0; left = extra; guard = 0;
        beg = 1; adi = addr; rnw = 0; bsz = 8'(burst); bei = be;
        if (!hit(addr)) begin
            exp_err[b+1] = 1;
            step();
            idle_inputs();
            step();
            return;
        end
        for (int i = 1; i <= WB; i++) exp_busy[b+i] = 1;
        step();
        beg = 0; bsz = 8'($urandom); bei = 4'($urandom); rnw = 1'($urandom);
        while ((acc < stop || left > 0) && guard < 400) begin
            guard++;
            dv = ($urandom_range(0, 99) < dv_pct);
            if (acc >= stop && acc < n) dv = 0;
            w = $urandom;
            if (dv && cyc > b + WB && acc < n) begin
                if (wq.size() > 0) w = wq.pop_front();
                for (int j = 0; j < 4; j++)
                    if (be[j]) mdl_mem[(idx + acc) % DEPTH][8*j +: 8] = w[8*j +: 8];
                acc++;
            end else if (acc >= stop) begin
                left--;
            end
            dvi = dv; adi = w;
            step();
        end
        dvi = 0; adi = '0; mend = 1;
        for (int c = cyc; c <= b + WB; c++) exp_busy[c] = 0;
        step();
        mend = 0; bsz = '0; bei = '0; rnw = 0;
    endtask

    initial begin
        int b, b1, r, bu, idx;
        logic [31:0] a;

        idle_inputs();
        rst_n = 0;
        step();
        chk_en = 1;
        step();
        rst_n = 1;
        step();

        // Preload words 0..63 so random traffic never reads uninitialised memory.
        for (int i = 0; i < 64; i++) wq.push_back($urandom);
        do_write(32'h0000_0000, 63, 4'hF, 100, 64, 0);

        // Single write stalled by busy, then single read.
        wq = {32'hDEAD_BEEF};
        b1 = cyc;
        do_write(32'h0000_1000, 0, 4'hF, 100, 1, 1);
        check_lit("t1_busy_first", obs_busy[b1+1], 32'd1);
        check_lit("t1_busy_last", obs_busy[b1+5], 32'd1);
        check_lit("t1_busy_drop", obs_busy[b1+6], 32'd0);
        check_lit("t1_model_word", mdl_mem[12'h400], 32'hDEAD_BEEF);
        b = cyc;
        do_read(32'h0000_1000, 0, 0, 0);
        check_lit("t1_read_valid", obs_dv[b+2], 32'd1);
        check_lit("t1_read_data", obs_data[b+2], 32'hDEAD_BEEF);
        check_lit("t1_read_end", obs_end[b+3], 32'd1);

        // Four-word burst write then burst read.
        wq = {32'h11, 32'h22, 32'h33, 32'h44};
        do_write(32'h0000_2000, 3, 4'hF, 100, 4, 0);
        b = cyc;
        do_read(32'h0000_2000, 3, 0, 0);
        check_lit("t2_beat0", obs_data[b+2], 32'h11);
        check_lit("t2_beat1", obs_data[b+3], 32'h22);
        check_lit("t2_beat2", obs_data[b+4], 32'h33);
        check_lit("t2_beat3", obs_data[b+5], 32'h44);
        check_lit("t2_end", obs_end[b+6], 32'd1);

        // Partial byte-enable write over a preset word.
        wq = {32'hFFFF_FFFF};
        do_write(32'h0000_3000, 0, 4'hF, 100, 1, 0);
        wq = {32'h1234_5678};
        do_write(32'h0000_3000, 0, 4'b0011, 100, 1, 0);
        check_lit("t3_model_merge", mdl_mem[12'hC00], 32'hFFFF_5678);
        b = cyc;
        do_read(32'h0000_3000, 0, 0, 0);
        check_lit("t3_read_merge", obs_data[b+2], 32'hFFFF_5678);

        // Out-of-range read.
        b = cyc;
        do_read(32'h0001_0000, 0, 0, 0);
        check_lit("t4_err_pulse", obs_err[b+1], 32'd1);
        check_lit("t4_err_clear", obs_err[b+2], 32'd0);
        check_lit("t4_no_valid", obs_dv[b+2], 32'd0);

        // Index wrap on write and read.
        wq = {32'hA5A5_0FFF, 32'h5A5A_0000};
        do_write(32'h0000_3FFC, 1, 4'hF, 100, 2, 0);
        b = cyc;
        do_read(32'h0000_3FFC, 1, 0, 0);
        check_lit("t5_wrap_hi", obs_data[b+2], 32'hA5A5_0FFF);
        check_lit("t5_wrap_lo", obs_data[b+3], 32'h5A5A_0000);

        // Reset during beat 2 of a 4-beat read; memory survives.
        b = cyc;
        do_read(32'h0000_2000, 3, 3, 3);
        check_lit("t6_reset_quiet", obs_dv[b+4], 32'd0);
        b = cyc;
        do_read(32'h0000_2000, 3, 0, 0);
        check_lit("t6_after_reset0", obs_data[b+2], 32'h11);
        check_lit("t6_after_reset3", obs_data[b+5], 32'h44);

        // Master ends a write while it is still stalled.
        do_write(32'h0000_1004, 0, 4'hF, 100, 0, 0);

        // Randomised traffic confined to the preloaded words.
        for (int t = 0; t < 160; t++) begin
            r   = $urandom_range(0, 10);
            bu  = $urandom_range(0, 7);
            idx = $urandom_range(0, 56);
            a   = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            if (r == 0) begin
                a = $urandom;
                if (a[31:14] == '0) a[31] = 1'b1;
                if ($urandom_range(0, 1) == 1) do_read(a, bu, 0, 0);
                else do_write(a, bu, 4'hF, 100, bu + 1, 0);
            end else if (r <= 4) begin
                do_read(a, bu, 0, 0);
            end else if (r <= 8) begin
                do_write(a, bu, 4'($urandom), $urandom_range(40, 100),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(0, bu) : bu + 1,
                         $urandom_range(0, 2));
            end else if (r == 9) begin
                do_read(a, bu, $urandom_range(1, 2), $urandom_range(1, RL + bu));
            end else begin
                do_read(a, bu, 3, $urandom_range(1, RL + bu));
            end
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
